// File: rtl/hazard_detection_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-branch flushes, data-memory wait states with a timeout trap,
// and a saturating count of stalled cycles.
module hazard_detection_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             control_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALT} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM  = 9'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [8:0]       wait_inc;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic uses_rs1, uses_rs2, load_use, mem_stall;
  logic pc_write_n, if_id_write_n, if_id_flush_n, control_sel_n;

  // Decode which source registers the instruction in ID actually reads.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (if_id_opcode)
      OP_LOAD, OP_IMM:            uses_rs1 = 1'b1;
      OP_STORE, OP_REG, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use  = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                      (uses_rs2 && (if_id_rs2 == id_ex_rd)));
  assign mem_stall = dmem_req && !dmem_ready;
  assign wait_inc  = {1'b0, wait_cnt_q} + 9'd1;

  // Next-state and Mealy output logic; a completed memory wait behaves
  // exactly like a cycle of the state that was frozen.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    eff_state     = state_q;
    pc_write_n    = 1'b1;
    if_id_write_n = 1'b1;
    if_id_flush_n = 1'b0;
    control_sel_n = 1'b0;

    if ((state_q == MEM_WAIT) && dmem_ready) begin
      eff_state  = ret_q;
      state_d    = ret_q;
      wait_cnt_d = 8'd0;
    end

    case (eff_state)
      RUN: begin
        if (mem_stall) begin
          pc_write_n    = 1'b0;
          if_id_write_n = 1'b0;
          wait_cnt_d    = 8'd1;
          ret_d         = RUN;
          state_d       = MEM_WAIT;
        end else if (branch_taken) begin
          if_id_flush_n = 1'b1;
          control_sel_n = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else if (load_use) begin
          pc_write_n    = 1'b0;
          if_id_write_n = 1'b0;
          control_sel_n = 1'b1;
          state_d       = RUN;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          // Freeze; flush_cnt is held so the flush resumes intact.
          pc_write_n    = 1'b0;
          if_id_write_n = 1'b0;
          wait_cnt_d    = 8'd1;
          ret_d         = FLUSH;
          state_d       = MEM_WAIT;
        end else begin
          if_id_flush_n = 1'b1;
          control_sel_n = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_RELOAD == 3'd0) ? RUN : FLUSH;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            state_d     = FLUSH;
          end
        end
      end
      MEM_WAIT: begin
        // Only reached with dmem_ready low: keep waiting or trap.
        pc_write_n    = 1'b0;
        if_id_write_n = 1'b0;
        wait_cnt_d    = wait_inc[7:0];
        if (wait_inc >= TIMEOUT_LIM) begin
          mem_timeout_d = 1'b1;
          state_d       = HALT;
        end
      end
      HALT: begin
        pc_write_n    = 1'b0;
        if_id_write_n = 1'b0;
        if_id_flush_n = 1'b1;
        control_sel_n = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (!pc_write_n && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
    else                                  stall_count_d = stall_count_q;
  end

  // While reset is held the pipeline is kept bubbled and frozen.
  always_comb begin
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      control_sel = 1'b1;
    end else begin
      pc_write    = pc_write_n;
      if_id_write = if_id_write_n;
      if_id_flush = if_id_flush_n;
      control_sel = control_sel_n;
    end
  end

  // State and counter registers; reset clears everything on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      ret_q         <= RUN;
      flush_cnt_q   <= 3'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a table of single-cycle
// decisions taken from RUN, plus multi-cycle sequences.
module tb_hazard_detection_unit;

  logic        clk;
  logic        reset;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
  logic        id_ex_mem_read, branch_taken, dmem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, control_sel, mem_timeout;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011;
  localparam logic [6:0] ITYP = 7'b0010011, BR = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111;

  // expected outputs packed as {pc_write, if_id_write, if_id_flush, control_sel}
  localparam logic [3:0] O_NORM = 4'b1100, O_LU = 4'b0001, O_BUB = 4'b1111;
  localparam logic [3:0] O_FRZ = 4'b0000, O_RST = 4'b0011;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, req, rdy;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[14];

  hazard_detection_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .if_id_opcode(if_id_opcode), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .control_sel(control_sel), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, pc_write, if_id_write, if_id_flush, control_sel}, {28'd0, exp});
  endtask

  task automatic idle();
    if_id_opcode = RTYP; if_id_rs1 = 5'd1; if_id_rs2 = 5'd2; id_ex_rd = 5'd3;
    id_ex_mem_read = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Holds reset for one edge, checks the forced outputs, and releases at a negedge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1 chk_out({nm, "_rst_out"}, O_RST);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic req, input logic rdy);
    if_id_opcode = op; if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
    id_ex_mem_read = mr; branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    tbl[0]  = '{"lu_add_rs1",   RTYP,  5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[1]  = '{"rd0_no_haz",   RTYP,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[2]  = '{"lui_no_haz",   LUI,   5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[3]  = '{"lu_add_rs2",   RTYP,  5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[4]  = '{"imm_rs2_no",   ITYP,  5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[5]  = '{"lu_store_rs2", STORE, 5'd2, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[6]  = '{"lu_br_rs1",    BR,    5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[7]  = '{"lu_load_rs1",  LOAD,  5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[8]  = '{"no_memread",   RTYP,  5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[9]  = '{"br_beats_lu",  RTYP,  5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BUB};
    tbl[10] = '{"mem_beats_all",RTYP,  5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ};
    tbl[11] = '{"req_ready",    RTYP,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM};
    tbl[12] = '{"jal_no_haz",   JAL,   5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[13] = '{"branch_only",  ITYP,  5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, O_BUB};

    // Table: each vector applied in RUN right after a reset.
    for (int i = 0; i < 14; i++) begin
      do_reset(tbl[i].nm);
      chk({tbl[i].nm, "_cnt0"}, 32'(stall_count), 32'd0);
      drive(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr, tbl[i].br,
            tbl[i].req, tbl[i].rdy);
      #1 chk_out(tbl[i].nm, tbl[i].exp);
    end

    // Load-use stalls exactly one cycle and is counted.
    do_reset("seq_lu");
    drive(RTYP, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk_out("seq_lu_stall", O_LU);
    @(negedge clk);
    idle();
    #1 chk_out("seq_lu_after", O_NORM);
    chk("seq_lu_cnt", 32'(stall_count), 32'd1);

    // Branch: two bubble cycles, then normal flow.
    do_reset("seq_br");
    branch_taken = 1'b1;
    #1 chk_out("seq_br_c1", O_BUB);
    @(negedge clk);
    branch_taken = 1'b0;
    #1 chk_out("seq_br_c2", O_BUB);
    @(negedge clk);
    #1 chk_out("seq_br_c3", O_NORM);
    chk("seq_br_cnt", 32'(stall_count), 32'd0);

    // Memory wait: three cycles frozen, resume when ready arrives.
    do_reset("seq_mw");
    for (int c = 0; c < 3; c++) begin
      drive(RTYP, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 chk_out("seq_mw_frozen", O_FRZ);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1 chk_out("seq_mw_resume", O_NORM);
    @(negedge clk);
    idle();
    #1 chk("seq_mw_cnt", 32'(stall_count), 32'd3);
    chk("seq_mw_to", 32'(mem_timeout), 32'd0);

    // Timeout: fifteen low cycles trap; HALT holds until reset.
    do_reset("seq_to");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1 chk_out("seq_to_frozen", O_FRZ);
      @(negedge clk);
      if (c == 14) chk("seq_to_not_yet", 32'(mem_timeout), 32'd0);
    end
    chk("seq_to_flag", 32'(mem_timeout), 32'd1);
    chk("seq_to_cnt15", 32'(stall_count), 32'd15);
    dmem_ready = 1'b1;
    #1 chk_out("seq_to_halt", O_RST);
    @(negedge clk);
    #1 chk_out("seq_to_halt2", O_RST);
    chk("seq_to_cnt16", 32'(stall_count), 32'd16);
    chk("seq_to_sticky", 32'(mem_timeout), 32'd1);
    do_reset("seq_to_clr");
    #1 chk("seq_to_clr_flag", 32'(mem_timeout), 32'd0);
    chk("seq_to_clr_cnt", 32'(stall_count), 32'd0);
    chk_out("seq_to_run", O_NORM);

    // Branch in FLUSH together with a memory stall: freeze first, then flush.
    do_reset("seq_fm");
    branch_taken = 1'b1;
    #1 chk_out("seq_fm_c1", O_BUB);
    @(negedge clk);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk_out("seq_fm_freeze", O_FRZ);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk_out("seq_fm_ret", O_BUB);
    @(negedge clk);
    idle();
    #1 chk_out("seq_fm_tail", O_BUB);
    @(negedge clk);
    #1 chk_out("seq_fm_run", O_NORM);
    chk("seq_fm_cnt", 32'(stall_count), 32'd1);

    // Reset mid-flush abandons the flush.
    do_reset("seq_rf");
    branch_taken = 1'b1;
    #1 chk_out("seq_rf_c1", O_BUB);
    do_reset("seq_rf_mid");
    #1 chk_out("seq_rf_run", O_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
